// File: rtl/ws2811_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2811_rx_pkg                                                 |
// | Purpose  : Shared constants, state encoding and timing helper for the    |
// |            WS2811 stream receiver.                                       |
// | Contents : rx_state_t      frame FSM state encoding                      |
// |            c_bits_per_pix  bits in one GRB pixel word                    |
// |            c_first_bit     bit index of the first (MSB) bit of a pixel   |
// |            c_*_lsb         GRB field positions inside the 24-bit word    |
// |            ns_to_clk()     ceil(ns * f_clk / 1e9), elaboration only      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ws2811_rx_pkg;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,   // waiting for a reset gap to align to frame start
      ST_IDLE = 2'd1,   // aligned, waiting for the first bit of a frame
      ST_HIGH = 2'd2,   // line high, bit in progress
      ST_LOW  = 2'd3    // line low between bits or heading into a gap
   } rx_state_t;

   localparam int         c_bits_per_pix = 24;
   localparam logic [4:0] c_first_bit    = 5'd23;

   // GRB word layout, MSB first on the wire
   localparam int c_g_lsb = 16;
   localparam int c_r_lsb = 8;
   localparam int c_b_lsb = 0;

   localparam longint c_ns_per_s = 64'd1_000_000_000;

   // Round up so that a threshold is never shorter than the nominal time.
   function automatic int ns_to_clk(input longint ns, input longint clk_hz);
      return int'((ns * clk_hz + c_ns_per_s - 64'd1) / c_ns_per_s);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ws2811_rx_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2811_rx_pulse                                               |
// | Purpose  : Line front end: 2-FF synchronizer, edge detection, high-time  |
// |            and low-time counters, and bit/gap classification.            |
// | Ports    : sysclk    in  system clock                                    |
// |            reset_n   in  asynchronous active-low reset                   |
// |            din       in  raw line, asynchronous                          |
// |            rise      out rising edge seen (registered)                   |
// |            bit_valid out high pulse in [HI_MIN, HI_MAX] just ended       |
// |            bit_val   out decoded value accompanying bit_valid            |
// |            bit_err   out high pulse shorter than HI_MIN just ended       |
// |            hi_tmo    out high time just exceeded HI_MAX                  |
// |            gap       out low time just reached LO_RESET (one cycle)      |
// | Latency  : 3 clk from din to event outputs.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ws2811_rx_pulse #(
   parameter int HI_MIN    = 8,
   parameter int HI_THRESH = 30,
   parameter int HI_MAX    = 50,
   parameter int LO_RESET  = 2458
) (
   input  logic sysclk,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic bit_valid,
   output logic bit_val,
   output logic bit_err,
   output logic hi_tmo,
   output logic gap
);
   import ws2811_rx_pkg::*;

   localparam int c_hw = $clog2(HI_MAX + 2);
   localparam int c_lw = $clog2(LO_RESET + 1);

   localparam logic [c_hw-1:0] c_hi_min = c_hw'(HI_MIN);
   localparam logic [c_hw-1:0] c_hi_thr = c_hw'(HI_THRESH);
   localparam logic [c_hw-1:0] c_hi_max = c_hw'(HI_MAX);
   localparam logic [c_hw-1:0] c_hi_sat = c_hw'(HI_MAX + 1);
   localparam logic [c_lw-1:0] c_lo_gap = c_lw'(LO_RESET - 1);
   localparam logic [c_lw-1:0] c_lo_sat = c_lw'(LO_RESET);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_prev;
   logic [c_hw-1:0] r_hi_cnt;
   logic [c_lw-1:0] r_lo_cnt;

   logic w_rise;
   logic w_fall;
   logic w_tmo;
   logic w_ok;
   logic w_short;
   logic w_gap;

   // r_hi_cnt holds the number of cycles the synced line has been high,
   // counting the rise cycle as the first; on the fall cycle it is the
   // full pulse width. A width of HI_MAX+1 was already reported as a
   // timeout, so its falling edge is left silent.
   always_comb begin
      w_rise  = r_sync2 & ~r_prev;
      w_fall  = ~r_sync2 & r_prev;
      w_tmo   = r_sync2 & ~w_rise & (r_hi_cnt == c_hi_max);
      w_ok    = w_fall & (r_hi_cnt >= c_hi_min) & (r_hi_cnt <= c_hi_max);
      w_short = w_fall & (r_hi_cnt < c_hi_min);
      w_gap   = ~r_sync2 & ~w_fall & (r_lo_cnt == c_lo_gap);
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_prev    <= 1'b0;
         r_hi_cnt  <= '0;
         r_lo_cnt  <= '0;
         rise      <= 1'b0;
         bit_valid <= 1'b0;
         bit_val   <= 1'b0;
         bit_err   <= 1'b0;
         hi_tmo    <= 1'b0;
         gap       <= 1'b0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;

         if (w_rise)
            r_hi_cnt <= c_hw'(1);
         else if (r_sync2 && (r_hi_cnt != c_hi_sat))
            r_hi_cnt <= r_hi_cnt + c_hw'(1);

         // Low time counts from the fall; the line staying low out of
         // reset also counts, which lets a quiet line align the receiver.
         if (r_sync2)
            r_lo_cnt <= '0;
         else if (w_fall)
            r_lo_cnt <= c_lw'(1);
         else if (r_lo_cnt != c_lo_sat)
            r_lo_cnt <= r_lo_cnt + c_lw'(1);

         rise      <= w_rise;
         bit_valid <= w_ok;
         bit_val   <= (r_hi_cnt >= c_hi_thr);
         bit_err   <= w_short;
         hi_tmo    <= w_tmo;
         gap       <= w_gap;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ws2811_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2811_rx                                                     |
// | Purpose  : Decodes a WS2811 NRZ LED stream (GRB, MSB first) into 24-bit  |
// |            pixel words, tracks frames and flags timing/length errors.    |
// | Ports    : sysclk      in   system clock                                 |
// |            reset_n     in   asynchronous active-low reset                |
// |            din         in   raw WS2811 line (asynchronous)               |
// |            pix_valid   out  one-cycle strobe, new pixel on addr/grb      |
// |            pix_addr    out  [3:0]  pixel index in frame                  |
// |            pix_grb     out  [23:0] decoded {G,R,B}                       |
// |            frame_done  out  one-cycle strobe at end of a non-empty frame |
// |            frame_count out  [15:0] completed frames, wrapping            |
// |            pix_count   out  [3:0]  pixels in last frame, saturating      |
// |            err_bit     out  sticky bit timing / partial pixel error      |
// |            err_ovf     out  sticky pixel overflow error                  |
// |            err_clr     in   clears sticky errors; a new error wins       |
// |            reg_raddr   in   [15:0] shadow read address (option only)     |
// |            reg_rdata   out  [31:0] shadow read data    (option only)     |
// | Options  : WS2811_RX_SHADOW_EN adds a NUM_LEDS x 24-bit shadow of the    |
// |            last pixels received, readable combinationally.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ws2811_rx #(
   parameter int SYSTEM_CLOCK  = 49_152_000,
   parameter int NUM_LEDS      = 7,
   parameter int T_HIGH_MIN_NS = 150,
   parameter int T_THRESH_NS   = 600,
   parameter int T_HIGH_MAX_NS = 1000,
   parameter int T_RESET_US    = 50
) (
   input  logic        sysclk,
   input  logic        reset_n,
   input  logic        din,
   output logic        pix_valid,
   output logic [3:0]  pix_addr,
   output logic [23:0] pix_grb,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic [3:0]  pix_count,
   output logic        err_bit,
   output logic        err_ovf,
   input  logic        err_clr
`ifdef WS2811_RX_SHADOW_EN
   ,
   input  logic [15:0] reg_raddr,
   output logic [31:0] reg_rdata
`endif
);
   import ws2811_rx_pkg::*;

   localparam int c_hi_min_clk = ns_to_clk(longint'(T_HIGH_MIN_NS), longint'(SYSTEM_CLOCK));
   localparam int c_thresh_clk = ns_to_clk(longint'(T_THRESH_NS), longint'(SYSTEM_CLOCK));
   localparam int c_hi_max_clk = ns_to_clk(longint'(T_HIGH_MAX_NS), longint'(SYSTEM_CLOCK));
   localparam int c_reset_clk  = ns_to_clk(longint'(T_RESET_US) * 64'd1000, longint'(SYSTEM_CLOCK));

   localparam logic [3:0] c_num_leds  = 4'(NUM_LEDS);
   localparam logic [3:0] c_last_addr = 4'(NUM_LEDS - 1);

   logic w_rise;
   logic w_bit_valid;
   logic w_bit_val;
   logic w_bit_err;
   logic w_hi_tmo;
   logic w_gap;

   ws2811_rx_pulse #(
      .HI_MIN    (c_hi_min_clk),
      .HI_THRESH (c_thresh_clk),
      .HI_MAX    (c_hi_max_clk),
      .LO_RESET  (c_reset_clk)
   ) u_pulse (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .din       (din),
      .rise      (w_rise),
      .bit_valid (w_bit_valid),
      .bit_val   (w_bit_val),
      .bit_err   (w_bit_err),
      .hi_tmo    (w_hi_tmo),
      .gap       (w_gap)
   );

   rx_state_t   r_state;
   logic [23:0] r_shift;
   logic [4:0]  r_bit_idx;
   logic [3:0]  r_pix_idx;   // next pixel index, saturates at NUM_LEDS
   logic [3:0]  r_pix_cnt;   // pixels this frame, saturates at 15
   logic        r_bits_seen;

   logic w_accept;
   logic w_pix_done;
   logic w_frame_end;
   logic w_set_bit;
   logic w_set_ovf;

   always_comb begin
      w_accept    = (r_state == ST_HIGH) & w_bit_valid;
      w_pix_done  = w_accept & (r_bit_idx == 5'd0);
      w_frame_end = (r_state == ST_LOW) & w_gap;
      // A bad pulse or timeout while a bit is in progress, or a frame that
      // closes in the middle of a pixel.
      w_set_bit   = ((r_state == ST_HIGH) & (w_bit_err | w_hi_tmo))
                  | (w_frame_end & (r_bit_idx != c_first_bit));
      w_set_ovf   = w_pix_done & (r_pix_idx >= c_num_leds);
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_SYNC;
         r_shift     <= '0;
         r_bit_idx   <= c_first_bit;
         r_pix_idx   <= '0;
         r_pix_cnt   <= '0;
         r_bits_seen <= 1'b0;
         pix_valid   <= 1'b0;
         pix_addr    <= '0;
         pix_grb     <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         pix_count   <= '0;
         err_bit     <= 1'b0;
         err_ovf     <= 1'b0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;

         if (w_set_bit)
            err_bit <= 1'b1;
         else if (err_clr)
            err_bit <= 1'b0;

         if (w_set_ovf)
            err_ovf <= 1'b1;
         else if (err_clr)
            err_ovf <= 1'b0;

         case (r_state)
            ST_SYNC: begin
               if (w_gap)
                  r_state <= ST_IDLE;
            end

            ST_IDLE: begin
               if (w_rise) begin
                  r_state     <= ST_HIGH;
                  r_bit_idx   <= c_first_bit;
                  r_pix_idx   <= '0;
                  r_pix_cnt   <= '0;
                  r_bits_seen <= 1'b0;
               end
            end

            ST_HIGH: begin
               if (w_hi_tmo) begin
                  // Line stuck high: the frame is unusable, realign.
                  r_state <= ST_SYNC;
               end else if (w_bit_err) begin
                  // Glitch: drop it and keep the pixel position.
                  r_state <= ST_LOW;
               end else if (w_bit_valid) begin
                  r_state     <= ST_LOW;
                  r_shift     <= {r_shift[22:0], w_bit_val};
                  r_bits_seen <= 1'b1;
                  if (r_bit_idx == 5'd0) begin
                     pix_valid <= 1'b1;
                     pix_grb   <= {r_shift[22:0], w_bit_val};
                     pix_addr  <= (r_pix_idx >= c_num_leds) ? c_last_addr : r_pix_idx;
                     r_bit_idx <= c_first_bit;
                     if (r_pix_idx != c_num_leds)
                        r_pix_idx <= r_pix_idx + 4'd1;
                     if (r_pix_cnt != 4'hF)
                        r_pix_cnt <= r_pix_cnt + 4'd1;
                  end else begin
                     r_bit_idx <= r_bit_idx - 5'd1;
                  end
               end
            end

            ST_LOW: begin
               if (w_rise) begin
                  r_state <= ST_HIGH;
               end else if (w_gap) begin
                  r_state <= ST_IDLE;
                  if (r_bits_seen) begin
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                     pix_count   <= r_pix_cnt;
                  end
               end
            end

            default: r_state <= ST_SYNC;
         endcase
      end
   end

`ifdef WS2811_RX_SHADOW_EN
   // One register per real pixel; the table is padded to the full 4-bit
   // address range with constant zeros so the read needs no range logic
   // beyond the NUM_LEDS compare.
   logic [23:0] w_shadow [16];

   for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
      if (gi < NUM_LEDS) begin : g_entry
         logic [23:0] r_word;
         always_ff @(posedge sysclk or negedge reset_n) begin
            if (!reset_n)
               r_word <= '0;
            else if (pix_valid && (pix_addr == 4'(gi)))
               r_word <= pix_grb;
         end
         assign w_shadow[gi] = r_word;
      end else begin : g_pad
         assign w_shadow[gi] = '0;
      end
   end

   assign reg_rdata = (reg_raddr[3:0] < c_num_leds) ? {8'd0, w_shadow[reg_raddr[3:0]]} : 32'd0;
`endif

endmodule
`default_nettype wire
